prbs_checker: RTL and testbench



---
 rtl/prbs_pkg.sv | 18 +
 rtl/prbs_checker.sv | 148 ++++++++++++++
 tb/tb_prbs_checker.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: default LFSR length/taps, checker state type and
// the feedback recurrence used by both generator and checker.
package prbs_pkg;

  localparam int unsigned   PRBS_N   = 8;
  localparam logic [PRBS_N:0] PRBS_TAP = 9'b101110001;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_e;

  // Next bit of a Fibonacci LFSR; hist[0] is the newest bit.
  function automatic logic prbs_next(input logic [PRBS_N-1:0] hist);
    return ^(hist & PRBS_TAP[PRBS_N:1]);
  endfunction

endpackage

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: self-synchronises to a serial PRBS stream, then
// free-runs a reference LFSR, flagging bit errors and dropping lock on bursts.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned    N          = PRBS_N,
  parameter logic [N:0]     TAP        = PRBS_TAP,
  parameter int unsigned    LOCK_CNT   = 16,
  parameter int unsigned    WIN        = 64,
  parameter int unsigned    UNLOCK_ERR = 8,
  parameter int unsigned    CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             prbs_in,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int unsigned FW = $clog2(N + 1);
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WW = $clog2(WIN);
  localparam int unsigned EW = $clog2(UNLOCK_ERR + 1);

  localparam logic [N-1:0]  TAP_MASK = TAP[N:1];
  localparam logic [FW-1:0] FILL_N   = FW'(N);
  localparam logic [MW-1:0] LOCK_V   = MW'(LOCK_CNT);
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN - 1);
  localparam logic [EW-1:0] UNLOCK_V = EW'(UNLOCK_ERR);

  prbs_state_e      state_q, state_d;
  logic [N-1:0]     hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WW-1:0]    win_cnt_q, win_cnt_d;
  logic [EW-1:0]    win_err_q, win_err_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic             exp_bit;
  logic             mismatch;
  logic [EW-1:0]    win_err_nx;

  always_comb begin
    exp_bit    = ^(hist_q & TAP_MASK);
    mismatch   = (prbs_in != exp_bit);
    win_err_nx = win_err_q + EW'(mismatch);

    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = match_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;

    if (en) begin
      case (state_q)
        SEARCH: begin
          hist_d = {hist_q[N-2:0], prbs_in};
          if (fill_q != FILL_N) begin
            fill_d = fill_q + 1'b1;
          end else if (hist_q != '0 && !mismatch) begin
            match_d = match_q + 1'b1;
            if (match_d == LOCK_V) begin
              state_d   = LOCKED;
              locked_d  = 1'b1;
              match_d   = '0;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Reference free-runs on its own prediction, not on the received bit.
          hist_d = {hist_q[N-2:0], exp_bit};
          err_d  = mismatch;
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
          if (mismatch && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          // Unlock is checked first so it wins over the end-of-window clear.
          if (win_err_nx == UNLOCK_V) begin
            state_d   = SEARCH;
            locked_d  = 1'b0;
            fill_d    = '0;
            match_d   = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_nx;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (clr) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEARCH;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Testbench for prbs_checker: golden LFSR stream, expectations queued at drive
// time and compared one cycle later just after the sampling edge.
module tb_prbs_checker;

  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          prbs_in = 1'b0;
  logic          clr = 1'b0;
  logic          locked;
  logic          err;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] bit_cnt;

  prbs_checker #(
    .N(8), .TAP(9'b101110001), .LOCK_CNT(16), .WIN(64), .UNLOCK_ERR(8), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .prbs_in(prbs_in), .clr(clr),
    .locked(locked), .err(err), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    xl;
    bit    xe;
    int    xec;
    int    xbc;
    string nm;
  } exp_t;

  typedef struct {
    bit en;
    bit flip;
    bit clr;
    bit xe;
    int xec;
    int xbc;
  } vec_t;

  exp_t     sb[$];
  int       n_vec  = 0;
  int       n_miss = 0;
  logic [7:0] g;

  task automatic check(input string nm, input bit xl, input bit xe, input int xec, input int xbc);
    n_vec++;
    if (locked !== xl || err !== xe || int'(err_cnt) != xec || int'(bit_cnt) != xbc) begin
      n_miss++;
      $display("FAIL %s: got locked=%0b err=%0b err_cnt=%0d bit_cnt=%0d, want locked=%0b err=%0b err_cnt=%0d bit_cnt=%0d",
               nm, locked, err, err_cnt, bit_cnt, xl, xe, xec, xbc);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check(x.nm, x.xl, x.xe, x.xec, x.xbc);
      end
    end
  end

  task automatic next_bit(output bit b);
    b = g[7];
    g = {g[6:0], ^(g & 8'hB8)};
  endtask

  task automatic step_raw(input bit e, input bit b, input bit c, input bit xl, input bit xe,
                          input int xec, input int xbc, input string nm);
    exp_t x;
    @(negedge clk);
    en = e; prbs_in = b; clr = c;
    x.xl = xl; x.xe = xe; x.xec = xec; x.xbc = xbc; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic step(input bit e, input bit flip, input bit c, input bit xl, input bit xe,
                      input int xec, input int xbc, input string nm);
    bit b;
    if (e) begin
      next_bit(b);
      b = b ^ flip;
    end else begin
      b = 1'($urandom);
    end
    step_raw(e, b, c, xl, xe, xec, xbc, nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; clr = 1'b0; prbs_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{en:1'b1, flip:1'b1, clr:1'b0, xe:1'b1, xec:1, xbc:977};
    tbl[1] = '{en:1'b1, flip:1'b0, clr:1'b0, xe:1'b0, xec:1, xbc:978};
    tbl[2] = '{en:1'b0, flip:1'b0, clr:1'b0, xe:1'b0, xec:1, xbc:978};
    tbl[3] = '{en:1'b1, flip:1'b1, clr:1'b0, xe:1'b1, xec:2, xbc:979};
    tbl[4] = '{en:1'b0, flip:1'b0, clr:1'b0, xe:1'b0, xec:2, xbc:979};
    tbl[5] = '{en:1'b1, flip:1'b0, clr:1'b0, xe:1'b0, xec:2, xbc:980};
    tbl[6] = '{en:1'b1, flip:1'b1, clr:1'b1, xe:1'b1, xec:0, xbc:0};
    tbl[7] = '{en:1'b1, flip:1'b0, clr:1'b0, xe:1'b0, xec:0, xbc:1};
    tbl[8] = '{en:1'b1, flip:1'b1, clr:1'b0, xe:1'b1, xec:1, xbc:2};

    #2 rst_n = 1'b0;
    #1 check("reset_init", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean lock on golden stream, seed 4B: lock on bit 24, bit_cnt from bit 25.
    g = 8'h4B;
    for (int i = 1; i <= 1000; i++)
      step(1'b1, 1'b0, 1'b0, i >= 24, 1'b0, 0, (i > 24) ? i - 24 : 0, $sformatf("clean_%0d", i));

    // Single errors, en gaps and clr-with-error from the table.
    for (int i = 0; i < 9; i++)
      step(tbl[i].en, tbl[i].flip, tbl[i].clr, 1'b1, tbl[i].xe, tbl[i].xec, tbl[i].xbc,
           $sformatf("tbl_%0d", i));

    // Run to the end of the current window; clear counters on its last bit.
    for (int k = 1; k <= 41; k++)
      step(1'b1, 1'b0, k == 41, 1'b1, 1'b0, (k == 41) ? 0 : 1, (k == 41) ? 0 : 2 + k,
           $sformatf("pad_%0d", k));

    // Burst of 8 errors in a fresh window: lock drops on the 8th.
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 1'b1, 1'b0, j < 7, 1'b1, j + 1, 2 * j + 1, $sformatf("burst_err_%0d", j));
      if (j < 7)
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, j + 1, 2 * j + 2, $sformatf("burst_ok_%0d", j));
    end
    for (int k = 1; k <= 24; k++)
      step(1'b1, 1'b0, 1'b0, k == 24, 1'b0, 8, 15, $sformatf("relock_%0d", k));

    // Five errors then clr: counters clear, lock retained.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, "clr_pre");
    for (int j = 1; j <= 5; j++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, j, 2 * j - 1, $sformatf("e5_err_%0d", j));
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, j, 2 * j, $sformatf("e5_ok_%0d", j));
    end
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, "clr_5");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, "clr_after");

    // Asynchronous reset in the middle of a cycle while locked.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Dead line: all zeros, then all ones.
    for (int k = 0; k < 500; k++)
      step_raw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, $sformatf("dead0_%0d", k));
    for (int k = 0; k < 500; k++)
      step_raw(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, $sformatf("dead1_%0d", k));

    // Gapped input: stream advances only on en=1, junk on prbs_in while en=0.
    do_reset();
    g = 8'h4B;
    begin
      int k;
      k = 0;
      for (int c = 0; c < 120; c++) begin
        if (c % 2 == 0) k++;
        step(c % 2 == 0, 1'b0, 1'b0, k >= 24, 1'b0, 0, (k > 24) ? k - 24 : 0,
             $sformatf("gap_%0d", c));
      end
    end

    @(negedge clk);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
